ysyx_25040101_lsu: RTL and testbench

Load/store unit between the execute stage (ALU address result, rs2 data) and register writeback. It turns one load or store request into an AXI4-Lite master transaction, with single-outstanding, multi-cycle handshaking. It handles byte-lane steering, write strobes, load extraction and zero/sign extension, and returns the result through a valid/ready response port. It replaces zero-latency DPI memory access so that the core can stall on real memory latency.

---
 rtl/ysyx_25040101_lsu_pkg.sv | 32 +++
 rtl/ysyx_25040101_lsu_align.sv | 52 +++++
 rtl/ysyx_25040101_lsu.sv | 178 +++++++++++++++++
 tb/tb_ysyx_25040101_lsu.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040101_lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, AXI response
// codes, FSM state encoding and the access alignment check.
package ysyx_25040101_lsu_pkg;

  // Access size codes (req_size_i)
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // AXI response codes
  localparam logic [1:0] OKAY = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWr,
    StWrResp,
    StResp
  } state_e;

  // True when the access can never reach the bus: illegal size or misaligned address.
  function automatic logic access_bad(logic [1:0] size, logic [1:0] addr_lo);
    unique case (size)
      SZ_B:    access_bad = 1'b0;
      SZ_H:    access_bad = addr_lo[0];
      SZ_W:    access_bad = |addr_lo;
      default: access_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25040101_lsu_align.sv
// Byte-lane steering for the load/store unit. Purely combinational.
// Ports:
//   addr_lo    - low two bits of the byte address
//   size       - access size code
//   sext       - sign-extend byte/half loads
//   wdata      - store data, value in the low bits
//   rdata      - raw 32-bit read beat from the bus
//   lane_wdata - store data replicated across all lanes
//   lane_wstrb - write strobes for the addressed lanes
//   ld_data    - load value shifted down, masked and extended
module ysyx_25040101_lsu_align
  import ysyx_25040101_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_wstrb,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    lane_wdata = 32'h0;
    lane_wstrb = 4'b0000;
    ld_data    = 32'h0;
    shifted    = rdata >> {addr_lo, 3'b000};

    unique case (size)
      SZ_B: begin
        lane_wdata = {4{wdata[7:0]}};
        lane_wstrb = 4'b0001 << addr_lo;
        ld_data    = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        lane_wdata = {2{wdata[15:0]}};
        lane_wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        ld_data    = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        lane_wdata = wdata;
        lane_wstrb = 4'b1111;
        ld_data    = rdata;
      end
      default: ;  // illegal size never reaches the bus
    endcase
  end

endmodule

// File: rtl/ysyx_25040101_lsu.sv
// Load/store unit: turns one load or store request into a single-outstanding
// AXI4-Lite master transaction and returns the result on a valid/ready port.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   req_*                 - request from execute (we, size, sext, addr, wdata)
//   resp_*                - response to writeback (rdata, err)
//   ar*/r*                - AXI4-Lite read address / read data channels
//   aw*/w*/b*             - AXI4-Lite write address / write data / write response
module ysyx_25040101_lsu
  import ysyx_25040101_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_sext_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [31:0]       rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [31:0]       wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  state_e            state_q, state_d;
  logic              we_q, sext_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic [ADDR_W-1:0] addr_aligned;
  logic [31:0]       lane_wdata, ld_data;
  logic [3:0]        lane_wstrb;

  assign accept       = req_valid_i & req_ready_o;
  assign addr_aligned = {addr_q[ADDR_W-1:2], 2'b00};
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  ysyx_25040101_lsu_align u_align (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .sext       (sext_q),
    .wdata      (wdata_q),
    .rdata      (rdata_i),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .ld_data    (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    araddr_o     = '0;
    arvalid_o    = 1'b0;
    rready_o     = 1'b0;
    awaddr_o     = '0;
    awvalid_o    = 1'b0;
    wdata_o      = 32'h0;
    wstrb_o      = 4'b0000;
    wvalid_o     = 1'b0;
    bready_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          rdata_d = 32'h0;
          err_d   = 1'b0;
          if (access_bad(req_size_i, req_addr_i[1:0])) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = req_we_i ? StWr : StRdAddr;
          end
        end
      end
      StRdAddr: begin
        arvalid_o = 1'b1;
        araddr_o  = addr_aligned;
        if (arready_i) state_d = StRdData;
      end
      StRdData: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          rdata_d = ld_data;
          err_d   = (rresp_i != OKAY);
          state_d = StResp;
        end
      end
      StWr: begin
        awaddr_o  = addr_aligned;
        wdata_o   = lane_wdata;
        wstrb_o   = lane_wstrb;
        awvalid_o = ~aw_done_q;
        wvalid_o  = ~w_done_q;
        aw_done_d = aw_done_q | awready_i;
        w_done_d  = w_done_q | wready_i;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrResp;
        end
      end
      StWrResp: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          err_d   = (bresp_i != OKAY);
          state_d = StResp;
        end
      end
      StResp: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      size_q    <= SZ_B;
      sext_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      if (accept) begin
        we_q    <= req_we_i;
        size_q  <= req_size_i;
        sext_q  <= req_sext_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040101_lsu.sv
// Directed self-checking bench for ysyx_25040101_lsu with a response scoreboard.
module tb_ysyx_25040101_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_we_i, req_sext_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic [31:0] araddr_o, rdata_i, awaddr_o, wdata_o;
  logic        arvalid_o, arready_i, rvalid_i, rready_o;
  logic [1:0]  rresp_i, bresp_i;
  logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
  logic [3:0]  wstrb_o;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ysyx_25040101_lsu #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_size_i   (req_size_i),
    .req_sext_i   (req_sext_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .araddr_o     (araddr_o),
    .arvalid_o    (arvalid_o),
    .arready_i    (arready_i),
    .rdata_i      (rdata_i),
    .rresp_i      (rresp_i),
    .rvalid_i     (rvalid_i),
    .rready_o     (rready_o),
    .awaddr_o     (awaddr_o),
    .awvalid_o    (awvalid_o),
    .awready_i    (awready_i),
    .wdata_o      (wdata_o),
    .wstrb_o      (wstrb_o),
    .wvalid_o     (wvalid_o),
    .wready_i     (wready_i),
    .bresp_i      (bresp_i),
    .bvalid_i     (bvalid_i),
    .bready_o     (bready_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_resp(input logic [31:0] d, input logic e);
    sb_q.push_back({d, e});
  endtask

  // Present one request for one cycle; it is accepted at the edge in between.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    check("req_ready_idle", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_size_i  = sz;
    req_sext_i  = sx;
    req_addr_i  = a;
    req_wdata_i = d;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_wdata_i = 32'h0;
    check("req_ready_busy", req_ready_o, 0);
  endtask

  task automatic serve_read(input int delay, input logic [31:0] exp_addr,
                            input logic [31:0] rd, input logic [1:0] rr);
    int n = 0;
    while (!arvalid_o && n < 20) begin @(negedge clk); n++; end
    check("arvalid_seen", arvalid_o, 1);
    for (int d = 0; d < delay; d++) begin
      check("araddr_held", araddr_o, exp_addr);
      check("arvalid_held", arvalid_o, 1);
      @(negedge clk);
    end
    check("araddr", araddr_o, exp_addr);
    arready_i = 1'b1;
    @(negedge clk);
    arready_i = 1'b0;
    check("arvalid_drop", arvalid_o, 0);
    n = 0;
    while (!rready_o && n < 20) begin @(negedge clk); n++; end
    check("rready_seen", rready_o, 1);
    rvalid_i = 1'b1;
    rdata_i  = rd;
    rresp_i  = rr;
    @(negedge clk);
    rvalid_i = 1'b0;
    rdata_i  = 32'h0;
    rresp_i  = 2'b00;
  endtask

  task automatic serve_write(input int aw_delay, input int w_delay, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                             input logic [1:0] br);
    int  n = 0;
    int  cyc = 0;
    logic aw_hs = 1'b0;
    logic w_hs = 1'b0;
    while (!awvalid_o && n < 20) begin @(negedge clk); n++; end
    check("awvalid_seen", awvalid_o, 1);
    while (!(aw_hs && w_hs) && cyc < 50) begin
      check("awvalid_state", awvalid_o, !aw_hs);
      check("wvalid_state", wvalid_o, !w_hs);
      check("bready_early", bready_o, 0);
      if (!aw_hs) check("awaddr", awaddr_o, exp_addr);
      if (!w_hs) begin
        check("wdata", wdata_o, exp_wdata);
        check("wstrb", wstrb_o, exp_strb);
      end
      awready_i = !aw_hs && (cyc >= aw_delay);
      wready_i  = !w_hs && (cyc >= w_delay);
      @(negedge clk);
      if (awready_i) aw_hs = 1'b1;
      if (wready_i) w_hs = 1'b1;
      cyc++;
    end
    awready_i = 1'b0;
    wready_i  = 1'b0;
    check("write_handshakes_done", {aw_hs, w_hs}, 2'b11);
    check("awvalid_after", awvalid_o, 0);
    check("wvalid_after", wvalid_o, 0);
    check("bready", bready_o, 1);
    bvalid_i = 1'b1;
    bresp_i  = br;
    @(negedge clk);
    bvalid_i = 1'b0;
    bresp_i  = 2'b00;
  endtask

  // Wait for the response, compare with the scoreboard, hold ready low `hold` cycles.
  task automatic get_resp(input int max_wait, input int hold);
    int   n = 0;
    exp_t e;
    while (!resp_valid_o && n < max_wait) begin @(negedge clk); n++; end
    check("resp_valid", resp_valid_o, 1);
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
    for (int h = 0; h <= hold; h++) begin
      check("resp_valid_held", resp_valid_o, 1);
      check("resp_rdata", resp_rdata_o, e.rdata);
      check("resp_err", resp_err_o, e.err);
      check("req_ready_in_resp", req_ready_o, 0);
      check("bus_quiet", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}, 0);
      if (h == hold) resp_ready_i = 1'b1;
      @(negedge clk);
    end
    resp_ready_i = 1'b0;
    check("resp_valid_drop", resp_valid_o, 0);
    check("req_ready_after", req_ready_o, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready_o, 1);
    check({tag, "_valids"}, {arvalid_o, awvalid_o, wvalid_o, resp_valid_o}, 0);
    check({tag, "_readys"}, {rready_o, bready_o}, 0);
    check({tag, "_rdata"}, resp_rdata_o, 0);
    check({tag, "_err"}, resp_err_o, 0);
    check({tag, "_araddr"}, araddr_o, 0);
    check({tag, "_awaddr"}, awaddr_o, 0);
    check({tag, "_wdata"}, wdata_o, 0);
    check({tag, "_wstrb"}, wstrb_o, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_size_i   = 2'd0;
    req_sext_i   = 1'b0;
    req_addr_i   = 32'h0;
    req_wdata_i  = 32'h0;
    resp_ready_i = 1'b0;
    arready_i    = 1'b0;
    rdata_i      = 32'h0;
    rresp_i      = 2'b00;
    rvalid_i     = 1'b0;
    awready_i    = 1'b0;
    wready_i     = 1'b0;
    bresp_i      = 2'b00;
    bvalid_i     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // LB signed, top byte 0x80
    expect_resp(32'hFFFF_FF80, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0);
    serve_read(0, 32'h8000_0000, 32'h80AB_CD12, 2'b00);
    get_resp(0, 0);

    // LBU, same data
    expect_resp(32'h0000_0080, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0);
    serve_read(0, 32'h8000_0000, 32'h80AB_CD12, 2'b00);
    get_resp(0, 0);

    // LH signed upper half, arready delayed 3 cycles
    expect_resp(32'h0000_1234, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0);
    serve_read(3, 32'h8000_0000, 32'h1234_8001, 2'b00);
    get_resp(0, 0);

    // LH lower half, signed and unsigned
    expect_resp(32'hFFFF_8001, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h8000_0000, 32'h0);
    serve_read(0, 32'h8000_0000, 32'h1234_8001, 2'b00);
    get_resp(0, 0);
    expect_resp(32'h0000_8001, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h8000_0000, 32'h0);
    serve_read(0, 32'h8000_0000, 32'h1234_8001, 2'b00);
    get_resp(0, 0);

    // SB lane 1, awready two cycles before wready
    expect_resp(32'h0, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00A5);
    serve_write(0, 2, 32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 2'b00);
    get_resp(0, 0);

    // SW misaligned: error in cycle 1, no bus traffic
    expect_resp(32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h8000_0006, 32'hCAFE_F00D);
    get_resp(0, 0);

    // LW with SLVERR: extracted value still returned
    expect_resp(32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0);
    serve_read(0, 32'h8000_0004, 32'hDEAD_BEEF, 2'b10);
    get_resp(0, 0);

    // SH upper half, wready before awready, response held 5 cycles
    expect_resp(32'h0, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_BEEF);
    serve_write(1, 0, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 2'b00);
    get_resp(0, 5);

    // SW aligned, both ready at once, DECERR response
    expect_resp(32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h8000_0008, 32'h1122_3344);
    serve_write(0, 0, 32'h8000_0008, 32'h1122_3344, 4'b1111, 2'b11);
    get_resp(0, 0);

    // Illegal size and misaligned half
    expect_resp(32'h0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0);
    get_resp(0, 0);
    expect_resp(32'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b1, 32'h8000_0001, 32'h0);
    get_resp(0, 0);

    // Reset while in RD_DATA aborts the load
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0);
    check("arvalid_pre_reset", arvalid_o, 1);
    arready_i = 1'b1;
    @(negedge clk);
    arready_i = 1'b0;
    check("rready_pre_reset", rready_o, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst_n = 1'b1;

    // Recovery: SB lane 3 after the abort
    expect_resp(32'h0, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h8000_0013, 32'h0000_1234);
    serve_write(0, 0, 32'h8000_0010, 32'h3434_3434, 4'b1000, 2'b00);
    get_resp(0, 0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
